// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl: valid/ready requests to BRAM port strobes, read data returned in order via a credit-limited response FIFO.
// Optional macro BRAM_PORT_CTRL_WRITE_RESP_EN: accepted writes also produce a response (write-first data).
module bram_port_ctrl #(
   parameter int DATA_SIZE  = 32,
   parameter int ADDR_SIZE  = 7,
   parameter int RESP_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [3:0]           req_wstrb,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [DATA_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [DATA_SIZE-1:0] resp_rdata,
   output logic                 bram_en,
   output logic [3:0]           bram_we,
   output logic [ADDR_SIZE-1:0] bram_addr,
   output logic [DATA_SIZE-1:0] bram_din,
   input  logic [DATA_SIZE-1:0] bram_dout
);
   localparam int PW = $clog2(RESP_DEPTH);
   localparam int CW = PW + 1;
   logic                 accept, resp_acc, pending, fifo_empty, push, pop;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        fifo_count, outstanding;
   logic [DATA_SIZE-1:0] fifo_mem [RESP_DEPTH];
   // Credit counts the in-flight read plus queued data, so bram_dout always has a slot.
   assign outstanding = fifo_count + CW'(pending);
   assign req_ready   = outstanding < CW'(RESP_DEPTH);
   assign accept      = req_valid & req_ready;
   assign bram_en     = accept;
   assign bram_we     = (accept & req_we) ? req_wstrb : 4'b0;
   assign bram_addr   = req_addr;
   assign bram_din    = req_wdata;
`ifdef BRAM_PORT_CTRL_WRITE_RESP_EN
   assign resp_acc    = accept;
`else
   assign resp_acc    = accept & ~req_we;
`endif
   assign fifo_empty  = fifo_count == '0;
   assign resp_valid  = pending | ~fifo_empty;
   assign resp_rdata  = fifo_empty ? bram_dout : fifo_mem[rd_ptr];
   assign pop         = ~fifo_empty & resp_ready;
   assign push        = pending & (~fifo_empty | ~resp_ready);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         pending    <= resp_acc;
         wr_ptr     <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bram_dout;
   end
endmodule
